// File: rtl/spi_write_controller.sv
// spi_write_controller
//   SPI mode 0 write-only controller. Each accepted command is serialised as a
//   16-bit frame {1'b1, addr[6:0], data[7:0]}, MSB first, followed by an
//   nCS-high gap before the next command is accepted.
//
// Parameters
//   CLK_DIV  SCLK half-period in clk cycles (1..255)
//   CS_GAP   nCS-high cycles after a frame before done/ready (1..255)
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_addr, cmd_data     register address and write data
//   busy                   frame or gap in progress
//   done                   one-cycle pulse on the last gap cycle
//   SCLK, nCS, COPI        SPI bus (all driven straight from flops)
module spi_write_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  // Gap cycle after which the last gap cycle begins; wraps to 8'hFF (never
  // reached) when CS_GAP is 1, where done is raised on the HOLD->GAP edge.
  localparam logic [7:0] GAP_PRE  = 8'(CS_GAP - 2);

  state_t      state;
  logic [7:0]  cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;

  // COPI is the MSB of the shift register, which is itself a flop; clearing
  // the register on entry to GAP returns COPI to 0 without a separate path.
  assign COPI = shreg[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      bit_cnt   <= 5'd0;
      shreg     <= 16'd0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      SCLK      <= 1'b0;
      nCS       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (!cmd_ready) begin
            // First edge after reset release: open for commands.
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            shreg     <= {1'b1, cmd_addr, cmd_data};
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            nCS       <= 1'b0;
            cnt       <= 8'd0;
            bit_cnt   <= 5'd0;
            state     <= SETUP;
          end
        end

        SETUP, LOW: begin
          if (cnt == DIV_LAST) begin
            cnt   <= 8'd0;
            SCLK  <= 1'b1;
            state <= HIGH;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        HIGH: begin
          if (cnt == DIV_LAST) begin
            cnt     <= 8'd0;
            SCLK    <= 1'b0;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              state <= HOLD;
            end else begin
              // Next bit appears on the falling edge, a full half-period
              // ahead of the next rising edge.
              shreg <= {shreg[14:0], 1'b0};
              state <= LOW;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt   <= 8'd0;
            nCS   <= 1'b1;
            shreg <= 16'd0;
            done  <= (CS_GAP == 1);
            state <= GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt       <= 8'd0;
            bit_cnt   <= 5'd0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            done <= (cnt == GAP_PRE);
            cnt  <= cnt + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
